fx2_in_stream_buffer: RTL and testbench



---
 rtl/fx2_pkg.sv | 18 +
 rtl/fx2_in_stream_buffer_if.sv | 23 ++
 rtl/fx2_sync_fifo.sv | 51 +++++
 rtl/fx2_in_stream_buffer.sv | 89 ++++++++
 tb/tb_fx2_in_stream_buffer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: endpoint addresses, Stream-IN FSM states
// and the default full-packet size.
package fx2_pkg;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  localparam int PKT_WORDS_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    COMMIT = 2'd2
  } stream_state_e;

endpackage

// File: rtl/fx2_in_stream_buffer_if.sv
// Producer handshake plus FX2 slave-FIFO pins for the Stream-IN buffer.
interface fx2_in_stream_buffer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        fx2_flagc;
  logic [15:0] fx2_fdata;
  logic [1:0]  fx2_faddr;
  logic        fx2_slwr;
  logic        fx2_slrd;
  logic        fx2_sloe;
  logic        fx2_pkt_end;

  modport slave (
    input  s_data, s_valid, fx2_flagc,
    output s_ready, fx2_fdata, fx2_faddr, fx2_slwr, fx2_slrd, fx2_sloe, fx2_pkt_end
  );

  modport master (
    output s_data, s_valid, fx2_flagc,
    input  s_ready, fx2_fdata, fx2_faddr, fx2_slwr, fx2_slrd, fx2_sloe, fx2_pkt_end
  );
endinterface

// File: rtl/fx2_sync_fifo.sv
// Single-clock FIFO with a combinational head word; DEPTH must be a power of 2.
module fx2_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fx2_in_stream_buffer.sv
// Buffers producer words and drains them into FX2 EP6, committing short
// packets with PKTEND after an idle timeout or when streaming is disabled.
module fx2_in_stream_buffer
  import fx2_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int PKT_WORDS    = PKT_WORDS_DEFAULT,
  parameter  int IDLE_TIMEOUT = 64,
  localparam int LW           = $clog2(DEPTH) + 1,
  localparam int WCW          = $clog2(PKT_WORDS),
  localparam int ICW          = $clog2(IDLE_TIMEOUT)
) (
  input  logic                    fx2_ifclk,
  input  logic                    reset,
  input  logic                    enable,
  output logic [LW-1:0]           level,
  fx2_in_stream_buffer_if.slave   bus
);

  stream_state_e  state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic [15:0]    head;
  logic           full, empty, push, wr, commit_go;

  fx2_sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk     (fx2_ifclk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (wr),
    .din_i   (bus.s_data),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.s_ready = !full;
  assign push        = bus.s_valid && !full;
  assign wr          = (state_q == STREAM) && !empty && bus.fx2_flagc;
  assign commit_go   = (state_q == COMMIT) && bus.fx2_flagc;

  assign bus.fx2_fdata   = empty ? 16'h0000 : head;
  assign bus.fx2_slwr    = !wr;
  assign bus.fx2_pkt_end = !commit_go;
  assign bus.fx2_faddr   = EP6;
  assign bus.fx2_slrd    = 1'b1;
  assign bus.fx2_sloe    = 1'b1;

  assign idle_inc = idle_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = '0;
    // Full packets are auto-committed by the FX2, so the count simply wraps.
    if (wr) word_cnt_d = (word_cnt_q == WCW'(PKT_WORDS - 1)) ? '0 : word_cnt_q + 1'b1;
    if (commit_go) word_cnt_d = '0;
    unique case (state_q)
      IDLE: if (enable) state_d = STREAM;
      STREAM: begin
        if (empty && word_cnt_q != '0) idle_cnt_d = idle_inc;
        // Decide on the post-pop count so a wrap this cycle never yields a
        // zero-length commit. The timeout fires as the counter reaches its
        // limit, putting PKTEND exactly IDLE_TIMEOUT cycles after the last strobe.
        if (!enable)
          state_d = (word_cnt_d != '0) ? COMMIT : IDLE;
        else if (empty && word_cnt_q != '0 && idle_inc == ICW'(IDLE_TIMEOUT - 1))
          state_d = COMMIT;
        if (state_d != STREAM) idle_cnt_d = '0;
      end
      COMMIT: if (bus.fx2_flagc) state_d = enable ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fx2_ifclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_fx2_in_stream_buffer.sv
// Directed bench for the FX2 Stream-IN buffer: reset, throughput, backpressure,
// idle-timeout commit, disable commit and commit held off by a full endpoint.
module tb_fx2_in_stream_buffer;
  import fx2_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  // Monitor-owned bookkeeping (updated on negedges).
  int cyc = 0, push_word = 0, exp_word = 0, strobes = 0;
  int pe_cnt = 0, pe_gap = 0, last_wr = 0, ord_bad = 0, excl_bad = 0;
  int prod_lim = 0;

  fx2_in_stream_buffer_if bus ();

  fx2_in_stream_buffer #(.DEPTH(16), .PKT_WORDS(256), .IDLE_TIMEOUT(64)) dut (
    .fx2_ifclk (clk),
    .reset     (rst),
    .enable    (enable),
    .level     (level),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Producer: presents consecutive values until prod_lim words were accepted.
  always @(posedge clk) begin
    #1;
    bus.s_valid = (push_word < prod_lim);
    bus.s_data  = push_word[15:0];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_word <= push_word;
    end else begin
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) push_word <= push_word + 1;
      if (bus.fx2_slwr === 1'b0) begin
        if (bus.fx2_fdata !== exp_word[15:0]) ord_bad <= ord_bad + 1;
        exp_word <= exp_word + 1;
        strobes  <= strobes + 1;
        last_wr  <= cyc;
      end
      if (bus.fx2_pkt_end === 1'b0) begin
        pe_cnt <= pe_cnt + 1;
        pe_gap <= cyc - last_wr;
      end
      if (bus.fx2_slwr === 1'b0 && bus.fx2_pkt_end === 1'b0) excl_bad <= excl_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int k = 0;
    while (strobes < n && k < 2000) begin nclk(); k++; end
    chk(tag, strobes, n);
  endtask

  task automatic wait_pe(input int n, input string tag);
    int k = 0;
    while (pe_cnt < n && k < 300) begin nclk(); k++; end
    chk(tag, pe_cnt, n);
  endtask

  initial begin
    int c0;
    int k;
    rst = 1'b1;
    enable = 1'b0;
    bus.fx2_flagc = 1'b1;
    step(3);
    nclk();
    chk("rst_level", level, 0);
    chk("rst_slwr", bus.fx2_slwr, 1);
    chk("rst_pkt_end", bus.fx2_pkt_end, 1);
    chk("rst_fdata", bus.fx2_fdata, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("faddr", bus.fx2_faddr, 2);
    chk("slrd_sloe", {bus.fx2_slrd, bus.fx2_sloe}, 2'b11);

    // Fill 5 words while idle, then stall EP, stream, and reset mid-stream.
    step(1);
    rst = 1'b0;
    prod_lim = 5;
    step(10);
    nclk();
    chk("idle_level", level, 5);
    chk("idle_no_wr", strobes, 0);
    step(1);
    enable = 1'b1;
    bus.fx2_flagc = 1'b0;
    step(3);
    nclk();
    chk("stall_level", level, 5);
    chk("stall_state", 32'(dut.state_q), 32'(STREAM));
    step(1);
    rst = 1'b1;
    step(2);
    nclk();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_slwr", bus.fx2_slwr, 1);
    chk("mid_rst_pkt_end", bus.fx2_pkt_end, 1);
    chk("mid_rst_fdata", bus.fx2_fdata, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    step(1);
    rst = 1'b0;
    bus.fx2_flagc = 1'b1;
    step(80);
    chk("post_rst_no_pe", pe_cnt, 0);
    chk("post_rst_no_wr", strobes, 0);

    // Two full packets back-to-back: words 5..516.
    c0 = cyc;
    prod_lim = 517;
    wait_strobes(512, "full_pkt_strobes");
    chk("full_pkt_rate", (cyc - c0) <= 520, 1);
    step(100);
    chk("full_pkt_no_pe", pe_cnt, 0);
    chk("full_pkt_wcnt", dut.word_cnt_q, 0);
    chk("full_pkt_order", ord_bad, 0);

    // Backpressure: EP full for 40 cycles while 40 words are offered.
    bus.fx2_flagc = 1'b0;
    prod_lim = 557;
    step(40);
    nclk();
    chk("bp_level", level, 16);
    chk("bp_s_ready", bus.s_ready, 0);
    chk("bp_no_wr", strobes, 512);
    step(1);
    bus.fx2_flagc = 1'b1;
    wait_strobes(552, "bp_strobes");
    chk("bp_order", ord_bad, 0);
    wait_pe(1, "bp_timeout_pe");
    chk("bp_timeout_gap", pe_gap, 64);
    step(2);
    chk("bp_wcnt_clr", dut.word_cnt_q, 0);

    // Short packet of 10 words closed by the idle timeout.
    prod_lim = 567;
    wait_strobes(562, "short_strobes");
    wait_pe(2, "short_pe");
    chk("short_gap", pe_gap, 64);
    step(2);
    chk("short_wcnt_clr", dut.word_cnt_q, 0);
    chk("short_single_pe", pe_cnt, 2);

    // Disable after 3 words: immediate commit, then IDLE buffers new words.
    prod_lim = 570;
    wait_strobes(565, "dis_strobes");
    step(1);
    enable = 1'b0;
    step(5);
    chk("dis_pe", pe_cnt, 3);
    chk("dis_state", 32'(dut.state_q), 32'(IDLE));
    prod_lim = 574;
    step(10);
    nclk();
    chk("dis_level", level, 4);
    chk("dis_no_wr", strobes, 565);
    step(1);
    enable = 1'b1;
    wait_strobes(569, "resume_strobes");

    // Timeout commit while the endpoint is full.
    step(1);
    bus.fx2_flagc = 1'b0;
    k = 0;
    while (dut.state_q != COMMIT && k < 200) begin nclk(); k++; end
    chk("cmt_state", 32'(dut.state_q), 32'(COMMIT));
    repeat (7) nclk();
    chk("cmt_hold_pkt_end", bus.fx2_pkt_end, 1);
    chk("cmt_hold_pe", pe_cnt, 3);
    step(1);
    bus.fx2_flagc = 1'b1;
    nclk();
    chk("cmt_pkt_end", bus.fx2_pkt_end, 0);
    chk("cmt_slwr", bus.fx2_slwr, 1);
    step(3);
    chk("cmt_one_pe", pe_cnt, 4);
    chk("cmt_wcnt_clr", dut.word_cnt_q, 0);
    chk("cmt_state_back", 32'(dut.state_q), 32'(STREAM));
    chk("final_order", ord_bad, 0);
    chk("excl_wr_pe", excl_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
